// File: rtl/uart_tx_fifo_param_if.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_param_if
//   Write-side handshake bundle of the parametrised UART transmitter.
//   The producer (CPU/debug bus side) offers a character with in_valid and
//   in_data; the transmitter answers with in_ready. A character is taken on
//   every clock edge where in_valid and in_ready are both high.
//
//   Signals
//     in_data   DATA_BITS  character to queue (LSB is sent first)
//     in_valid  1          in_data holds a character to queue
//     in_ready  1          transmitter FIFO has a free entry
//
//   Modports
//     master    producer side: drives in_data/in_valid, observes in_ready
//     slave     transmitter side: observes in_data/in_valid, drives in_ready
// -----------------------------------------------------------------------------
interface uart_tx_fifo_param_if #(
    parameter int DATA_BITS = 8
);

    logic [DATA_BITS-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/uart_tx_fifo_param.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_param
//   Parametrised RS-232 transmitter with a write-side FIFO and an internal
//   fractional baud generator. Characters are queued through a valid/ready
//   handshake and shifted out LSB first as
//     start(0), DATA_BITS data bits, optional parity bit, STOP_BITS stop(1).
//   Frames queued back-to-back follow each other with no idle bit between
//   the last stop bit and the next start bit.
//
//   Parameters
//     DATA_BITS  data bits per frame, 5..8
//     PARITY     0 = none, 1 = odd, 2 = even
//     STOP_BITS  1 or 2
//     DEPTH      FIFO entries, power of two, >= 2
//     ACC_W      baud accumulator width
//     INC        accumulator increment; bit rate = mclk * INC / 2**ACC_W
//
//   Ports
//     mclk        in   system clock
//     reset       in   synchronous, active-high, highest priority
//     bus         if   slave side of the in_data/in_valid/in_ready handshake
//     serial      out  TX line, idle high
//     busy        out  frame in progress or FIFO non-empty
//     fifo_count  out  characters currently queued
//     baud_tick   out  one-cycle pulse per bit period
//
//   All outputs are driven straight from flops.
// -----------------------------------------------------------------------------
module uart_tx_fifo_param #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int DEPTH     = 16,
    parameter int ACC_W     = 14,
    parameter int INC       = 38
) (
    input  logic                   mclk,
    input  logic                   reset,
    uart_tx_fifo_param_if.slave    bus,
    output logic                   serial,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   baud_tick
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]    ONE_C   = CW'(1);
    localparam logic [CW-1:0]    ZERO_C  = {CW{1'b0}};
    localparam logic [AW-1:0]    PTR_ONE = AW'(1);
    localparam logic [ACC_W:0]   INC_W   = (ACC_W + 1)'(INC);
    localparam logic [3:0]       BITS_C  = 4'(DATA_BITS);
    localparam logic [1:0]       STOPS_C = 2'(STOP_BITS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

    // Parity bit sent after the data bits: XOR of the data for even parity,
    // its complement for odd parity.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data);
        logic xor_v;
        xor_v = ^data;
        if (PARITY == 1) begin
            return ~xor_v;
        end else begin
            return xor_v;
        end
    endfunction

    // ------------------------------------------------------------------
    // Baud generator
    // ------------------------------------------------------------------
    logic [ACC_W-1:0] acc_r;
    logic [ACC_W:0]   sum_s;
    logic             baud_tick_r;

    // The extra top bit of the sum is the carry out of the accumulator.
    assign sum_s = {1'b0, acc_r} + INC_W;

    // Free-running phase accumulator; the registered carry is the bit tick.
    always_ff @(posedge mclk) begin
        if (reset) begin
            acc_r       <= {ACC_W{1'b0}};
            baud_tick_r <= 1'b0;
        end else begin
            acc_r       <= sum_s[ACC_W-1:0];
            baud_tick_r <= sum_s[ACC_W];
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem_r [DEPTH];
    logic [AW-1:0]        wr_ptr_r;
    logic [AW-1:0]        rd_ptr_r;
    logic [CW-1:0]        count_r;
    logic [CW-1:0]        count_nxt_s;
    logic                 in_ready_r;
    logic                 push_s;
    logic                 pop_s;

    // in_ready_r is already low when full, so a push can never overflow.
    assign push_s = bus.in_valid & in_ready_r;

    // Occupancy after this edge; a simultaneous push and pop cancel out.
    always_comb begin
        count_nxt_s = count_r;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + ONE_C;
        end else if (!push_s && pop_s) begin
            count_nxt_s = count_r - ONE_C;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Storage array; it holds no control state, so it is not reset.
    always_ff @(posedge mclk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= bus.in_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; in_ready is
    // registered from the next occupancy so it falls right after the last
    // free entry is taken.
    always_ff @(posedge mclk) begin
        if (reset) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= ZERO_C;
            in_ready_r <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r    <= count_nxt_s;
            in_ready_r <= (count_nxt_s != DEPTH_C);
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    state_t               state_r;
    state_t               state_nxt_s;
    logic [DATA_BITS-1:0] shreg_r;
    logic [DATA_BITS-1:0] shreg_nxt_s;
    logic [3:0]           bitcnt_r;
    logic [3:0]           bitcnt_nxt_s;
    logic [1:0]           stopcnt_r;
    logic [1:0]           stopcnt_nxt_s;
    logic                 serial_r;
    logic                 serial_nxt_s;
    logic                 par_r;
    logic                 par_nxt_s;
    logic                 busy_r;
    logic                 launch_s;

    // Next-state and line-level decisions; nothing moves except on a tick.
    // The level chosen here is presented on serial for the whole following
    // bit period, so each case emits the level of the *next* bit.
    always_comb begin
        state_nxt_s   = state_r;
        shreg_nxt_s   = shreg_r;
        bitcnt_nxt_s  = bitcnt_r;
        stopcnt_nxt_s = stopcnt_r;
        serial_nxt_s  = serial_r;
        par_nxt_s     = par_r;
        launch_s      = 1'b0;
        pop_s         = 1'b0;
        if (baud_tick_r) begin
            case (state_r)
                ST_IDLE: begin
                    launch_s = 1'b1;
                end
                ST_START: begin
                    serial_nxt_s = shreg_r[0];
                    shreg_nxt_s  = {1'b0, shreg_r[DATA_BITS-1:1]};
                    bitcnt_nxt_s = 4'd1;
                    state_nxt_s  = ST_DATA;
                end
                ST_DATA: begin
                    if (bitcnt_r < BITS_C) begin
                        serial_nxt_s = shreg_r[0];
                        shreg_nxt_s  = {1'b0, shreg_r[DATA_BITS-1:1]};
                        bitcnt_nxt_s = bitcnt_r + 4'd1;
                    end else if (PARITY != 0) begin
                        serial_nxt_s = par_r;
                        state_nxt_s  = ST_PAR;
                    end else begin
                        serial_nxt_s  = 1'b1;
                        stopcnt_nxt_s = 2'd1;
                        state_nxt_s   = ST_STOP;
                    end
                end
                ST_PAR: begin
                    serial_nxt_s  = 1'b1;
                    stopcnt_nxt_s = 2'd1;
                    state_nxt_s   = ST_STOP;
                end
                ST_STOP: begin
                    if (stopcnt_r < STOPS_C) begin
                        serial_nxt_s  = 1'b1;
                        stopcnt_nxt_s = stopcnt_r + 2'd1;
                    end else begin
                        // Last stop bit ends: decide like IDLE on this same
                        // tick so queued frames follow without a gap.
                        launch_s = 1'b1;
                    end
                end
                default: begin
                    serial_nxt_s = 1'b1;
                    state_nxt_s  = ST_IDLE;
                end
            endcase

            if (launch_s) begin
                if (count_r != ZERO_C) begin
                    // Data and its parity are captured together so later
                    // FIFO writes cannot disturb the frame in flight.
                    pop_s        = 1'b1;
                    shreg_nxt_s  = mem_r[rd_ptr_r];
                    par_nxt_s    = parity_bit(mem_r[rd_ptr_r]);
                    serial_nxt_s = 1'b0;
                    state_nxt_s  = ST_START;
                end else begin
                    serial_nxt_s = 1'b1;
                    state_nxt_s  = ST_IDLE;
                end
            end else begin
                pop_s = 1'b0;
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // FSM state, shifter, counters and the registered line/busy outputs.
    always_ff @(posedge mclk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            shreg_r   <= {DATA_BITS{1'b0}};
            bitcnt_r  <= 4'd0;
            stopcnt_r <= 2'd0;
            serial_r  <= 1'b1;
            par_r     <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            shreg_r   <= shreg_nxt_s;
            bitcnt_r  <= bitcnt_nxt_s;
            stopcnt_r <= stopcnt_nxt_s;
            serial_r  <= serial_nxt_s;
            par_r     <= par_nxt_s;
            busy_r    <= (state_nxt_s != ST_IDLE) | (count_nxt_s != ZERO_C);
        end
    end

    assign bus.in_ready = in_ready_r;
    assign serial       = serial_r;
    assign busy         = busy_r;
    assign fifo_count   = count_r;
    assign baud_tick    = baud_tick_r;

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo_param
//   Three transmitter instances with different frame formats and FIFO depths
//   run side by side. Each has its own random producer and its own monitor.
//   Accepted characters go into a scoreboard queue; the monitor derives the
//   expected line level, tick, busy, fifo_count and in_ready every cycle from
//   the frame rules and the bit-rate arithmetic and compares them with the
//   DUT outputs.
//     cfg0: 8-N-1, DEPTH 16, INC 4   (tick every 4th cycle)
//     cfg1: 7-E-2, DEPTH 4,  INC 4
//     cfg2: 5-O-1, DEPTH 2,  INC 3   (fractional: 5 or 6 cycles per bit)
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo_param;

    localparam int ACC_W = 4;

    logic mclk = 1'b0;
    always #5 mclk = ~mclk;

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;

    task automatic check(input int g, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL cfg%0d %s @%0t: got %0h expected %0h", g, name, $time, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int DB  = (g == 0) ? 8 : (g == 1) ? 7 : 5;
        localparam int PA  = (g == 0) ? 0 : (g == 1) ? 2 : 1;
        localparam int SB  = (g == 1) ? 2 : 1;
        localparam int DP  = (g == 0) ? 16 : (g == 1) ? 4 : 2;
        localparam int NC  = (g == 2) ? 3 : 4;
        localparam int CWB = $clog2(DP) + 1;

        logic           rst;
        logic           serial;
        logic           busy;
        logic           baud_tick;
        logic [CWB-1:0] fifo_count;

        uart_tx_fifo_param_if #(.DATA_BITS(DB)) bus ();

        uart_tx_fifo_param #(
            .DATA_BITS (DB),
            .PARITY    (PA),
            .STOP_BITS (SB),
            .DEPTH     (DP),
            .ACC_W     (ACC_W),
            .INC       (NC)
        ) dut (
            .mclk       (mclk),
            .reset      (rst),
            .bus        (bus),
            .serial     (serial),
            .busy       (busy),
            .fifo_count (fifo_count),
            .baud_tick  (baud_tick)
        );

        // Reference model state
        logic [7:0] sb_q[$];      // characters accepted, not yet started
        bit         bits_q[$];    // remaining levels of the frame on the line
        logic       cur_level  = 1'b1;
        logic       in_frame   = 1'b0;
        logic       start_pend = 1'b0;
        logic       armed      = 1'b0;
        logic       tick_m     = 1'b0;
        int         k          = 0;

        // Monitor / scoreboard: model updates on the rising edge, all
        // comparisons on the falling edge.
        initial begin : mon
            logic [7:0] b;
            int         ones;
            logic       accept;
            forever begin
                @(posedge mclk);
                if (rst === 1'b1) begin
                    sb_q.delete();
                    bits_q.delete();
                    cur_level  = 1'b1;
                    in_frame   = 1'b0;
                    start_pend = 1'b0;
                    tick_m     = 1'b0;
                    k          = 0;
                    armed      = 1'b1;
                end else if (armed) begin
                    accept = (bus.in_valid === 1'b1) && (sb_q.size() < DP);
                    if (start_pend) begin
                        b    = sb_q.pop_front();
                        ones = 0;
                        for (int i = 0; i < DB; i++) begin
                            bits_q.push_back(b[i]);
                            ones += int'(b[i]);
                        end
                        if (PA == 2) bits_q.push_back((ones % 2) == 1);
                        if (PA == 1) bits_q.push_back((ones % 2) == 0);
                        for (int i = 0; i < SB; i++) bits_q.push_back(1'b1);
                        start_pend = 1'b0;
                    end
                    if (accept) sb_q.push_back(8'(bus.in_data));
                    k++;
                    // A tick follows every edge where k*INC crosses a
                    // multiple of 2**ACC_W.
                    tick_m = (((k * NC) >> ACC_W) != (((k - 1) * NC) >> ACC_W));
                end
                @(negedge mclk);
                if (armed) begin
                    check(g, "serial",     32'(serial),     32'(cur_level));
                    check(g, "baud_tick",  32'(baud_tick),  32'(tick_m));
                    check(g, "fifo_count", 32'(fifo_count), 32'(sb_q.size()));
                    check(g, "in_ready",   32'(bus.in_ready), 32'(sb_q.size() < DP));
                    check(g, "busy",       32'(busy),       32'(in_frame || (sb_q.size() != 0)));
                    if (tick_m) begin
                        if (bits_q.size() != 0) begin
                            cur_level = bits_q.pop_front();
                        end else if (sb_q.size() != 0) begin
                            cur_level  = 1'b0;
                            in_frame   = 1'b1;
                            start_pend = 1'b1;
                        end else begin
                            cur_level = 1'b1;
                            in_frame  = 1'b0;
                        end
                    end
                end
            end
        end

        // Producer: reset, mid-frame reset, directed characters, random phases.
        initial begin : stim
            logic [7:0] dir_bytes [0:2];
            logic [7:0] ch;
            int         w;
            int         c;
            int         prob [0:3];
            dir_bytes[0] = 8'h55;
            dir_bytes[1] = 8'h03;
            dir_bytes[2] = 8'h07;
            prob[0] = 10;
            prob[1] = 80;
            prob[2] = 100;
            prob[3] = 3;

            rst          = 1'b1;
            bus.in_valid = 1'b0;
            bus.in_data  = '0;
            repeat (3) @(posedge mclk);
            #1 rst = 1'b0;

            // One character, then reset in the middle of its frame.
            bus.in_valid = 1'b1;
            bus.in_data  = DB'(8'hA5);
            @(posedge mclk);
            #1 bus.in_valid = 1'b0;
            repeat (20) @(posedge mclk);
            #1 rst = 1'b1;
            bus.in_valid = 1'b1;
            repeat (3) @(posedge mclk);
            #1 rst = 1'b0;
            bus.in_valid = 1'b0;

            // Directed characters followed by a held-valid burst A0..A5.
            for (int i = 0; i < 9; i++) begin
                ch           = (i < 3) ? dir_bytes[i] : (8'hA0 + 8'(i - 3));
                bus.in_valid = 1'b1;
                bus.in_data  = DB'(ch);
                w = 0;
                do begin
                    @(negedge mclk);
                    w++;
                end while (bus.in_ready !== 1'b1 && w < 2000);
                check(g, "ready_wait", 32'(w < 2000), 32'd1);
                @(posedge mclk);
                #1;
            end
            bus.in_valid = 1'b0;

            // Random traffic at several offered loads.
            for (int p = 0; p < 4; p++) begin
                for (int i = 0; i < 150; i++) begin
                    bus.in_valid = ($urandom_range(99) < prob[p]);
                    bus.in_data  = DB'($urandom);
                    @(posedge mclk);
                    #1;
                end
            end
            bus.in_valid = 1'b0;

            c = 0;
            while ((busy !== 1'b0 || sb_q.size() != 0 || in_frame) && c < 5000) begin
                @(posedge mclk);
                c++;
            end
            check(g, "drain", 32'(c < 5000), 32'd1);
            repeat (10) @(posedge mclk);
            done_cnt++;
        end
    end

    // Global bound and summary.
    initial begin : finisher
        int c;
        c = 0;
        while (done_cnt < 3 && c < 30000) begin
            @(posedge mclk);
            c++;
        end
        vectors++;
        if (done_cnt < 3) begin
            miscompares++;
            $display("FAIL global_timeout: got %0d configs done expected 3", done_cnt);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
